// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: code constants, FSM states,
// code selection and a behavioural JK next-state helper.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } jk_state_t;

    // Until the flop state is known, only explicit set/reset codes are safe.
    function automatic logic [1:0] jk_code(input logic model, input logic target,
                                           input logic toggle_mode, input logic synced);
        logic [1:0] code;
        if (!synced || ((model != target) && !toggle_mode)) begin
            code = target ? JK_SET : JK_RST;
        end else if (model != target) begin
            code = JK_TGL;
        end else begin
            code = JK_HOLD;
        end
        return code;
    endfunction

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic nq;
        case (jk)
            JK_RST:  nq = 1'b0;
            JK_SET:  nq = 1'b1;
            JK_TGL:  nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_bit_fifo.sv
// Single-bit FIFO holding desired Q values; pointers wrap modulo DEPTH (power of 2).
module jk_bit_fifo
    import jk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   din,
    input  logic                   pop,
    output logic                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives an external JK flop so its Q follows a buffered stream of desired bits,
// checking the Q feedback two edges after each issued code.
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit TOGGLE_MODE = 1'b0,
    parameter bit HALT_ON_ERR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // Producer side: a bit transfers on a rising edge when in_valid && in_ready;
    // in_valid while in_ready is low is ignored and the producer must hold it.
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic [1:0]             jk,
    output logic                   jk_valid,
    input  logic                   q_fb,
    input  logic                   err_clr,
    output logic                   mismatch,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    jk_state_t state;
    jk_state_t state_nx;

    logic       fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       mis_det;
    logic [1:0] code;
    logic       model_q;
    logic       chk_valid;
    logic       chk_exp;

    jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   (in_bit),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign in_ready = !fifo_full;

    // A clearing cycle issues nothing, so the first code afterwards is explicit.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        code     = JK_HOLD;
        mis_det  = chk_valid && (q_fb != chk_exp);
        if ((state != HALT) && !fifo_empty && !err_clr) begin
            pop  = 1'b1;
            code = jk_code(model_q, fifo_dout, TOGGLE_MODE, state == RUN);
        end
        if (err_clr) begin
            state_nx = UNSYNC;
        end else begin
            case (state)
                UNSYNC:  if (pop) state_nx = RUN;
                RUN:     if (mis_det && HALT_ON_ERR) state_nx = HALT;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UNSYNC;
            jk        <= JK_HOLD;
            jk_valid  <= 1'b0;
            model_q   <= 1'b0;
            chk_valid <= 1'b0;
            chk_exp   <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            state    <= state_nx;
            jk       <= code;
            jk_valid <= pop;
            if (pop) begin
                model_q <= fifo_dout;
            end
            // The flop has applied the code by the next edge; q_fb is compared one edge later.
            chk_valid <= jk_valid && !err_clr;
            chk_exp   <= model_q;
            if (err_clr) begin
                mismatch <= 1'b0;
            end else if (mis_det) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule
